// File: rtl/modarith_pkg.sv
// rtl/modarith_pkg.sv - shared state encoding and width default for the modular arithmetic stages
package modarith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mod_state_t;

endpackage

// File: rtl/modmul_step.sv
// rtl/modmul_step.sv - one MSB-first interleaved modular multiply step
// Ports:
//   acc      - running accumulator, < p
//   x        - multiplicand, < p
//   p        - modulus
//   bit_in   - current multiplier bit
//   acc_next - ((2*acc) mod p + bit_in*x) mod p
module modmul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] p,
    input  logic             bit_in,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   dbl;
    logic [WIDTH-1:0] dbl_mod;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_mod;

    // Both operands of each reduction are below p, so the intermediate is
    // below 2p and a single conditional subtraction is enough.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_mod = (dbl >= {1'b0, p}) ? WIDTH'(dbl - {1'b0, p}) : dbl[WIDTH-1:0];
        sum     = {1'b0, dbl_mod} + {1'b0, x};
        sum_mod = (sum >= {1'b0, p}) ? WIDTH'(sum - {1'b0, p}) : sum[WIDTH-1:0];
        acc_next = bit_in ? sum_mod : dbl_mod;
    end

endmodule

// File: rtl/modular_divider.sv
// rtl/modular_divider.sv - computes (b * a_inverse) mod p with a bit-serial multiplier
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start              - begin a division, sampled only in IDLE
//   prime, a_inverse, b - modulus, inverse of the divisor, dividend
//   quotient, err      - result and operand error flag, held until next start
//   busy               - high during the WIDTH multiply cycles
//   done               - one-cycle completion pulse
module modular_divider
    import modarith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] prime,
    input  logic [WIDTH-1:0] a_inverse,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] TOP_BIT = CW'(WIDTH - 1);

    mod_state_t       state;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic             operand_bad;

    // Operands must all be residues below p, p must be a real modulus and the
    // inverse must be nonzero; anything else short-circuits to an error result.
    assign operand_bad = (prime < WIDTH'(2)) || (a_inverse == '0) ||
                         (a_inverse >= prime) || (b >= prime);

    modmul_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .x        (x_reg),
        .p        (p_reg),
        .bit_in   (b_reg[cnt]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            p_reg    <= '0;
            x_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p_reg <= prime;
                        x_reg <= a_inverse;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= TOP_BIT;
                        if (operand_bad) begin
                            state    <= DONE;
                            quotient <= '0;
                            err      <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        state    <= DONE;
                        quotient <= acc_next;
                        err      <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modular_divider.sv
// tb/tb_modular_divider.sv - directed self-checking bench for modular_divider
module tb_modular_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] prime;
    logic [7:0] a_inverse;
    logic [7:0] b;
    logic [7:0] quotient;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int failures;

    modular_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prime     (prime),
        .a_inverse (a_inverse),
        .b         (b),
        .quotient  (quotient),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and return latency (cycle index where done is seen,
    // cycle 1 = the cycle right after the accepting edge), busy cycle count and results.
    task automatic run_op(input logic [7:0] p, input logic [7:0] x, input logic [7:0] bb,
                          output int lat, output int busy_cnt,
                          output logic [7:0] q, output logic e);
        @(negedge clk);
        prime = p; a_inverse = x; b = bb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        q = quotient;
        e = err;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; prime = 8'd0; a_inverse = 8'd0; b = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({quotient, busy, done, err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%0d busy=%b done=%b err=%b want all 0", quotient, busy, done, err);
        end
        // Release reset and request in the same cycle: first edge must accept.
        rst = 1'b0; prime = 8'd5; a_inverse = 8'd2; b = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL first_start_accept: busy=%b want 1", busy);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] vp [5];
        logic [7:0] vx [5];
        logic [7:0] vb [5];
        logic [7:0] vq [5];
        int lat, bc;
        logic [7:0] q;
        logic e;
        vp = '{8'd5, 8'd13, 8'd251, 8'd13, 8'd251};
        vx = '{8'd2, 8'd6,  8'd250, 8'd6,  8'd1};
        vb = '{8'd4, 8'd7,  8'd250, 8'd12, 8'd250};
        vq = '{8'd3, 8'd3,  8'd1,   8'd7,  8'd250};
        for (int i = 0; i < 5; i++) begin
            run_op(vp[i], vx[i], vb[i], lat, bc, q, e);
            checks++;
            if (q !== vq[i] || e !== 1'b0) begin
                failures++;
                $display("FAIL basic_result[%0d]: got q=%0d err=%b want q=%0d err=0", i, q, e, vq[i]);
            end
            checks++;
            if (lat != 9 || bc != 8) begin
                failures++;
                $display("FAIL basic_timing[%0d]: got latency=%0d busy_cycles=%0d want 9 and 8", i, lat, bc);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 8'd250) begin
            failures++;
            $display("FAIL done_pulse_hold: got done=%b q=%0d want done=0 q=250", done, quotient);
        end
    endtask

    task automatic test_zero_b;
        int lat, bc;
        logic [7:0] q;
        logic e;
        run_op(8'd13, 8'd6, 8'd0, lat, bc, q, e);
        checks++;
        if (q !== 8'd0 || e !== 1'b0 || lat != 9) begin
            failures++;
            $display("FAIL zero_b: got q=%0d err=%b latency=%0d want q=0 err=0 latency=9", q, e, lat);
        end
    endtask

    task automatic test_invalid;
        logic [7:0] vp [4];
        logic [7:0] vx [4];
        logic [7:0] vb [4];
        int lat, bc;
        logic [7:0] q;
        logic e;
        vp = '{8'd13, 8'd13, 8'd13, 8'd1};
        vx = '{8'd0,  8'd13, 8'd6,  8'd1};
        vb = '{8'd7,  8'd7,  8'd20, 8'd0};
        for (int i = 0; i < 4; i++) begin
            // Leave a nonzero result behind so the clear-to-zero is visible.
            run_op(8'd5, 8'd2, 8'd4, lat, bc, q, e);
            run_op(vp[i], vx[i], vb[i], lat, bc, q, e);
            checks++;
            if (q !== 8'd0 || e !== 1'b1 || lat != 1 || bc != 0) begin
                failures++;
                $display("FAIL invalid[%0d]: got q=%0d err=%b latency=%0d busy_cycles=%0d want 0 1 1 0",
                         i, q, e, lat, bc);
            end
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL err_hold: got err=%b done=%b want err=1 done=0", err, done);
        end
    endtask

    task automatic test_ignore_start;
        int c;
        int extra_busy;
        @(negedge clk);
        prime = 8'd13; a_inverse = 8'd6; b = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 40) begin
            if (c == 3) begin
                start = 1'b1; prime = 8'd251; a_inverse = 8'd250; b = 8'd250;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        checks++;
        if (c != 9 || quotient !== 8'd3 || err !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_result: got latency=%0d q=%0d err=%b want 9 3 0", c, quotient, err);
        end
        extra_busy = 0;
        repeat (12) begin
            @(negedge clk);
            extra_busy += int'(busy) + int'(done);
        end
        checks++;
        if (extra_busy != 0 || quotient !== 8'd3) begin
            failures++;
            $display("FAIL ignore_start_no_queue: got activity=%0d q=%0d want 0 and q=3", extra_busy, quotient);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, n;
        @(negedge clk);
        prime = 8'd5; a_inverse = 8'd2; b = 8'd4; start = 1'b1;
        d1 = -1; d2 = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        start = 1'b0;
        n = 0;
        while ((busy || done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d1 < 0 || d2 < 0 || (d2 - d1) != 10) begin
            failures++;
            $display("FAIL back_to_back_period: got done at %0d and %0d want spacing 10", d1, d2);
        end
        checks++;
        if (quotient !== 8'd3 || busy || done) begin
            failures++;
            $display("FAIL back_to_back_end: got q=%0d busy=%b done=%b want 3 0 0", quotient, busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        int lat, bc;
        logic [7:0] q;
        logic e;
        @(negedge clk);
        prime = 8'd13; a_inverse = 8'd6; b = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({quotient, busy, done, err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_async: got q=%0d busy=%b done=%b err=%b want all 0", quotient, busy, done, err);
        end
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            seen_done += int'(done);
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_done += int'(done) + int'(busy);
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL reset_mid_abort: got %0d cycles of busy/done activity want 0", seen_done);
        end
        run_op(8'd13, 8'd6, 8'd12, lat, bc, q, e);
        checks++;
        if (q !== 8'd7 || e !== 1'b0 || lat != 9) begin
            failures++;
            $display("FAIL reset_mid_recover: got q=%0d err=%b latency=%0d want 7 0 9", q, e, lat);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_basic;
        test_zero_b;
        test_invalid;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
